tx_axis_arbiter: RTL and testbench

Packet-granular two-input AXI-Stream arbiter that shares the single 64-bit 10G MAC TX stream between the protocol TX engine (source 0) and the test-traffic packet generator (source 1). It grants whole packets round-robin and never interleaves beats of different packets. A beat-count watchdog truncates runaway packets so a stuck source cannot hold the MAC. It sits directly in front of the MAC TX AXI-Stream input.

---
 rtl/tx_axis_pkg.sv | 29 ++
 rtl/tx_axis_arbiter_if.sv | 22 ++
 rtl/axis_skid_buf.sv | 78 +++++++
 rtl/tx_axis_arbiter.sv | 171 +++++++++++++++++
 tb/tb_tx_axis_arbiter.sv | 308 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/tx_axis_pkg.sv
// +-------------------------------------------------------------------------+
// | tx_axis_pkg : shared types and constants for the TX AXI-Stream arbiter   |
// | Rev 1.0                                                                  |
// +-------------------------------------------------------------------------+
`timescale 1ns/1ps
`default_nettype none

package tx_axis_pkg;

  localparam int BC_W = 16;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    GRANT0 = 2'd1,
    GRANT1 = 2'd2,
    DRAIN  = 2'd3
  } arb_state_e;

  localparam logic [1:0] GNT_NONE = 2'b00;
  localparam logic [1:0] GNT_S0   = 2'b01;
  localparam logic [1:0] GNT_S1   = 2'b10;

  function automatic logic [1:0] gnt_onehot(input logic src);
    return src ? GNT_S1 : GNT_S0;
  endfunction

endpackage

`default_nettype wire

// File: rtl/tx_axis_arbiter_if.sv
// +-------------------------------------------------------------------------+
// | tx_axis_arbiter_if : AXI-Stream bundle (valid/ready/data/keep/last)      |
// | Rev 1.0                                                                  |
// +-------------------------------------------------------------------------+
`timescale 1ns/1ps
`default_nettype none

interface tx_axis_arbiter_if #(
  parameter int DATA_W = 64,
  parameter int KEEP_W = 8
);
  logic              tvalid;
  logic              tready;
  logic [DATA_W-1:0] tdata;
  logic [KEEP_W-1:0] tkeep;
  logic              tlast;

  modport master (output tvalid, tdata, tkeep, tlast, input tready);
  modport slave  (input tvalid, tdata, tkeep, tlast, output tready);
endinterface

`default_nettype wire

// File: rtl/axis_skid_buf.sv
// +-------------------------------------------------------------------------+
// | axis_skid_buf : 2-entry AXI-Stream skid buffer with registered ready     |
// | Rev 1.0                                                                  |
// +-------------------------------------------------------------------------+
`timescale 1ns/1ps
`default_nettype none

module axis_skid_buf #(
  parameter int DATA_W = 64,
  parameter int KEEP_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              s_valid_i,
  output logic              s_ready_o,
  input  logic [DATA_W-1:0] s_data_i,
  input  logic [KEEP_W-1:0] s_keep_i,
  input  logic              s_last_i,
  tx_axis_arbiter_if.master m_axis
);

  logic              out_valid_q;
  logic [DATA_W-1:0] out_data_q;
  logic [KEEP_W-1:0] out_keep_q;
  logic              out_last_q;
  logic              skid_valid_q;
  logic [DATA_W-1:0] skid_data_q;
  logic [KEEP_W-1:0] skid_keep_q;
  logic              skid_last_q;
  logic              in_fire;
  logic              out_free;

  // Ready depends only on skid occupancy, so m_axis.tready never reaches s_ready_o.
  assign s_ready_o = ~skid_valid_q;
  assign in_fire   = s_valid_i & ~skid_valid_q;
  assign out_free  = ~out_valid_q | m_axis.tready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
      out_keep_q   <= '0;
      out_last_q   <= 1'b0;
      skid_valid_q <= 1'b0;
      skid_data_q  <= '0;
      skid_keep_q  <= '0;
      skid_last_q  <= 1'b0;
    end else if (out_free) begin
      if (skid_valid_q) begin
        out_valid_q  <= 1'b1;
        out_data_q   <= skid_data_q;
        out_keep_q   <= skid_keep_q;
        out_last_q   <= skid_last_q;
        skid_valid_q <= 1'b0;
      end else begin
        out_valid_q <= in_fire;
        if (in_fire) begin
          out_data_q <= s_data_i;
          out_keep_q <= s_keep_i;
          out_last_q <= s_last_i;
        end
      end
    end else if (in_fire) begin
      skid_valid_q <= 1'b1;
      skid_data_q  <= s_data_i;
      skid_keep_q  <= s_keep_i;
      skid_last_q  <= s_last_i;
    end
  end

  assign m_axis.tvalid = out_valid_q;
  assign m_axis.tdata  = out_data_q;
  assign m_axis.tkeep  = out_keep_q;
  assign m_axis.tlast  = out_last_q;

endmodule

`default_nettype wire

// File: rtl/tx_axis_arbiter.sv
// +-------------------------------------------------------------------------+
// | tx_axis_arbiter : packet-granular round-robin 2:1 AXI-Stream arbiter     |
// | with beat-count watchdog. Optional TX_ARB_STATS_EN adds packet counters. |
// | Rev 1.0                                                                  |
// +-------------------------------------------------------------------------+
`timescale 1ns/1ps
`default_nettype none

module tx_axis_arbiter
  import tx_axis_pkg::*;
#(
  parameter int DATA_W    = 64,
  parameter int KEEP_W    = 8,
  parameter int MAX_BEATS = 1024
) (
  input  logic              clk,
  input  logic              rst,
  tx_axis_arbiter_if.slave  s0_axis,
  tx_axis_arbiter_if.slave  s1_axis,
  tx_axis_arbiter_if.master m_axis,
  output logic [1:0]        o_grant,
  output logic              o_trunc_err,
  input  logic              i_err_clr
`ifdef TX_ARB_STATS_EN
  ,
  output logic [31:0]       o_pkt_cnt0,
  output logic [31:0]       o_pkt_cnt1
`endif
);

  localparam logic [BC_W-1:0] BC_LIMIT = BC_W'(MAX_BEATS - 1);

  arb_state_e        state_q, state_d;
  logic [1:0]        grant_q, grant_d;
  logic              rr_q, rr_d;
  logic [BC_W-1:0]   bc_q, bc_d;
  logic              trunc_q;

  logic              src_sel;
  logic              src_valid;
  logic [DATA_W-1:0] src_data;
  logic [KEEP_W-1:0] src_keep;
  logic              src_last;
  logic              src_ready;
  logic              skid_ready;
  logic              push;
  logic              push_last;
  logic              trunc_set;
  logic              pref_valid;
  logic              oth_valid;

  assign src_sel    = grant_q[1];
  assign src_valid  = src_sel ? s1_axis.tvalid : s0_axis.tvalid;
  assign src_data   = src_sel ? s1_axis.tdata  : s0_axis.tdata;
  assign src_keep   = src_sel ? s1_axis.tkeep  : s0_axis.tkeep;
  assign src_last   = src_sel ? s1_axis.tlast  : s0_axis.tlast;
  assign pref_valid = rr_q ? s1_axis.tvalid : s0_axis.tvalid;
  assign oth_valid  = rr_q ? s0_axis.tvalid : s1_axis.tvalid;

  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    rr_d      = rr_q;
    bc_d      = bc_q;
    src_ready = 1'b0;
    push      = 1'b0;
    push_last = src_last;
    trunc_set = 1'b0;
    case (state_q)
      IDLE: begin
        if (pref_valid || oth_valid) begin
          state_d = (pref_valid ? rr_q : ~rr_q) ? GRANT1 : GRANT0;
          grant_d = gnt_onehot(pref_valid ? rr_q : ~rr_q);
          bc_d    = '0;
        end
      end
      GRANT0, GRANT1: begin
        src_ready = skid_ready;
        if (src_valid && skid_ready) begin
          push = 1'b1;
          bc_d = bc_q + BC_W'(1);
          if (src_last) begin
            rr_d    = ~src_sel;
            state_d = IDLE;
            grant_d = GNT_NONE;
          end else if (bc_q == BC_LIMIT) begin
            // Runaway packet: close it on the MAC side and swallow the rest.
            push_last = 1'b1;
            trunc_set = 1'b1;
            rr_d      = ~src_sel;
            state_d   = DRAIN;
          end
        end
      end
      DRAIN: begin
        src_ready = 1'b1;
        if (src_valid && src_last) begin
          state_d = IDLE;
          grant_d = GNT_NONE;
        end
      end
      default: begin
        state_d = IDLE;
        grant_d = GNT_NONE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      grant_q <= GNT_NONE;
      rr_q    <= 1'b0;
      bc_q    <= '0;
      trunc_q <= 1'b0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      rr_q    <= rr_d;
      bc_q    <= bc_d;
      if (i_err_clr) begin
        trunc_q <= 1'b0;
      end else if (trunc_set) begin
        trunc_q <= 1'b1;
      end
    end
  end

  assign s0_axis.tready = src_ready & grant_q[0];
  assign s1_axis.tready = src_ready & grant_q[1];
  assign o_grant        = grant_q;
  assign o_trunc_err    = trunc_q;

  axis_skid_buf #(
    .DATA_W (DATA_W),
    .KEEP_W (KEEP_W)
  ) u_skid (
    .clk       (clk),
    .rst       (rst),
    .s_valid_i (push),
    .s_ready_o (skid_ready),
    .s_data_i  (src_data),
    .s_keep_i  (src_keep),
    .s_last_i  (push_last),
    .m_axis    (m_axis)
  );

`ifdef TX_ARB_STATS_EN
  logic [31:0] pkt_cnt0_q;
  logic [31:0] pkt_cnt1_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pkt_cnt0_q <= '0;
      pkt_cnt1_q <= '0;
    end else if (push && push_last) begin
      if (src_sel) begin
        pkt_cnt1_q <= pkt_cnt1_q + 32'd1;
      end else begin
        pkt_cnt0_q <= pkt_cnt0_q + 32'd1;
      end
    end
  end

  assign o_pkt_cnt0 = pkt_cnt0_q;
  assign o_pkt_cnt1 = pkt_cnt1_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_tx_axis_arbiter.sv
// +-------------------------------------------------------------------------+
// | tb_tx_axis_arbiter : self-checking bench for tx_axis_arbiter             |
// | Rev 1.0                                                                  |
// +-------------------------------------------------------------------------+
`timescale 1ns/1ps
`default_nettype none

module tb_tx_axis_arbiter;
  import tx_axis_pkg::*;

  localparam int DW = 64;
  localparam int KW = 8;
  localparam int MAXB_MAIN = 1024;
  localparam int MAXB_WD   = 16;

  typedef struct packed {
    logic [DW-1:0] d;
    logic [KW-1:0] k;
    logic          l;
  } beat_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  tx_axis_arbiter_if #(.DATA_W(DW), .KEEP_W(KW)) s0_if ();
  tx_axis_arbiter_if #(.DATA_W(DW), .KEEP_W(KW)) s1_if ();
  tx_axis_arbiter_if #(.DATA_W(DW), .KEEP_W(KW)) m_if ();
  tx_axis_arbiter_if #(.DATA_W(DW), .KEEP_W(KW)) w0_if ();
  tx_axis_arbiter_if #(.DATA_W(DW), .KEEP_W(KW)) w1_if ();
  tx_axis_arbiter_if #(.DATA_W(DW), .KEEP_W(KW)) wm_if ();

  logic [1:0] grant, w_grant;
  logic       trunc, w_trunc;
  logic       err_clr, w_err_clr;
`ifdef TX_ARB_STATS_EN
  logic [31:0] cnt0, cnt1, wcnt0, wcnt1;
`endif

  tx_axis_arbiter #(.DATA_W(DW), .KEEP_W(KW), .MAX_BEATS(MAXB_MAIN)) dut (
    .clk (clk), .rst (rst),
    .s0_axis (s0_if), .s1_axis (s1_if), .m_axis (m_if),
    .o_grant (grant), .o_trunc_err (trunc), .i_err_clr (err_clr)
`ifdef TX_ARB_STATS_EN
    , .o_pkt_cnt0 (cnt0), .o_pkt_cnt1 (cnt1)
`endif
  );

  tx_axis_arbiter #(.DATA_W(DW), .KEEP_W(KW), .MAX_BEATS(MAXB_WD)) dut_wd (
    .clk (clk), .rst (rst),
    .s0_axis (w0_if), .s1_axis (w1_if), .m_axis (wm_if),
    .o_grant (w_grant), .o_trunc_err (w_trunc), .i_err_clr (w_err_clr)
`ifdef TX_ARB_STATS_EN
    , .o_pkt_cnt0 (wcnt0), .o_pkt_cnt1 (wcnt1)
`endif
  );

  beat_t q0[$];
  beat_t q1[$];
  beat_t expq[$];
  int    i0, i1;
  logic  v0, v1;
  int    tmode, gap;
  int    n_tests = 0;
  int    n_fail  = 0;
  int    s0_fires, nbeats;
  logic  hold_pend;
  beat_t hold;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic add_pkt(input int src, input int len);
    beat_t b;
    for (int j = 0; j < len; j++) begin
      b.d = {$urandom, $urandom};
      b.k = KW'($urandom);
      b.l = (j == len - 1);
      if (src == 0) q0.push_back(b); else q1.push_back(b);
    end
  endtask

  // Reference: whole packets, round-robin starting at s0, each packet cut to maxb beats.
  function automatic void build_expected(input int maxb);
    int p0 = 0, p1 = 0, p, n;
    bit rr = 1'b0, src, has0, has1, real_last;
    beat_t b;
    expq.delete();
    forever begin
      has0 = (p0 < q0.size());
      has1 = (p1 < q1.size());
      if (!has0 && !has1) break;
      src = (rr ? has1 : has0) ? rr : ~rr;
      p = src ? p1 : p0;
      n = 0;
      do begin
        b = src ? q1[p] : q0[p];
        real_last = b.l;
        p++;
        n++;
        if (n <= maxb) begin
          if (n == maxb) b.l = 1'b1;
          expq.push_back(b);
        end
      end while (!real_last);
      if (src) p1 = p; else p0 = p;
      rr = ~src;
    end
  endfunction

  task automatic drive_inputs();
    if (i0 < q0.size()) begin
      if (!v0) v0 = (i0 == 0 || q0[i0-1].l) || ($urandom_range(99) >= gap);
      s0_if.tdata = q0[i0].d; s0_if.tkeep = q0[i0].k; s0_if.tlast = q0[i0].l;
    end else begin
      v0 = 1'b0; s0_if.tdata = '0; s0_if.tkeep = '0; s0_if.tlast = 1'b0;
    end
    if (i1 < q1.size()) begin
      if (!v1) v1 = (i1 == 0 || q1[i1-1].l) || ($urandom_range(99) >= gap);
      s1_if.tdata = q1[i1].d; s1_if.tkeep = q1[i1].k; s1_if.tlast = q1[i1].l;
    end else begin
      v1 = 1'b0; s1_if.tdata = '0; s1_if.tkeep = '0; s1_if.tlast = 1'b0;
    end
    s0_if.tvalid = v0;
    s1_if.tvalid = v1;
    case (tmode)
      0: m_if.tready = 1'b1;
      1: m_if.tready = ~m_if.tready;
      default: m_if.tready = 1'($urandom_range(1));
    endcase
  endtask

  // Called at posedge+1; returns at posedge+1.
  task automatic run_traffic(input int stop_s0, input int budget);
    int    cyc = 0;
    logic  f0, f1;
    beat_t cur;
    while (!(i0 == q0.size() && i1 == q1.size() && expq.size() == 0) && cyc < budget) begin
      drive_inputs();
      @(negedge clk);
      f0 = s0_if.tvalid & s0_if.tready;
      f1 = s1_if.tvalid & s1_if.tready;
      if (f0) check("grant_s0", grant, GNT_S0);
      if (f1) check("grant_s1", grant, GNT_S1);
      cur = {m_if.tdata, m_if.tkeep, m_if.tlast};
      if (hold_pend) check("stall_stable", {m_if.tvalid, cur}, {1'b1, hold});
      if (m_if.tvalid && m_if.tready) begin
        nbeats++;
        if (expq.size() == 0) check("extra_beat", cur, '0);
        else check("beat", cur, expq.pop_front());
      end
      hold_pend = m_if.tvalid & ~m_if.tready;
      hold      = cur;
      @(posedge clk); #1;
      if (f0) begin i0++; v0 = 1'b0; s0_fires++; end
      if (f1) begin i1++; v1 = 1'b0; end
      cyc++;
      if (stop_s0 != 0 && s0_fires >= stop_s0) return;
    end
    check("drain_pending", expq.size(), 0);
  endtask

  task automatic check_reset();
    check("rst_m_tvalid", m_if.tvalid, 0);
    check("rst_m_tlast",  m_if.tlast, 0);
    check("rst_m_tdata",  m_if.tdata, 0);
    check("rst_m_tkeep",  m_if.tkeep, 0);
    check("rst_s_tready", {s0_if.tready, s1_if.tready}, 0);
    check("rst_grant",    grant, GNT_NONE);
    check("rst_trunc",    trunc, 0);
  endtask

  task automatic new_phase();
    q0.delete(); q1.delete(); expq.delete();
    i0 = 0; i1 = 0; v0 = 1'b0; v1 = 1'b0;
    s0_fires = 0; nbeats = 0; hold_pend = 1'b0;
    tmode = 0; gap = 0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    new_phase();
    drive_inputs();
    @(negedge clk);
    check_reset();
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  initial begin
    int sent, got;
    err_clr = 1'b0; w_err_clr = 1'b0;
    m_if.tready = 1'b0;
    w0_if.tvalid = 1'b0; w0_if.tdata = '0; w0_if.tkeep = '0; w0_if.tlast = 1'b0;
    w1_if.tvalid = 1'b0; w1_if.tdata = '0; w1_if.tkeep = '0; w1_if.tlast = 1'b0;
    wm_if.tready = 1'b1;

    // Single source: 4 x 512 beats from s1.
    do_reset();
    for (int p = 0; p < 4; p++) add_pkt(1, 512);
    build_expected(MAXB_MAIN);
    run_traffic(0, 3000);
    check("single_beats", nbeats, 2048);
    check("single_trunc", trunc, 0);

    // Contention: both sources 5 x 8 beats, continuously valid.
    do_reset();
    for (int p = 0; p < 5; p++) begin add_pkt(0, 8); add_pkt(1, 8); end
    build_expected(MAXB_MAIN);
    run_traffic(0, 400);
    check("cont_beats", nbeats, 80);
`ifdef TX_ARB_STATS_EN
    check("stats_cnt0", cnt0, 5);
    check("stats_cnt1", cnt1, 5);
`endif

    // Backpressure: m_axis_tready toggles every cycle.
    do_reset();
    tmode = 1;
    add_pkt(0, 16);
    build_expected(MAXB_MAIN);
    run_traffic(0, 200);
    check("bp_beats", nbeats, 16);

    // Randomized traffic.
    for (int r = 0; r < 4; r++) begin
      do_reset();
      tmode = 2;
      gap = $urandom_range(60);
      for (int p = $urandom_range(6); p > 0; p--) add_pkt(0, $urandom_range(40, 1));
      for (int p = $urandom_range(6); p > 0; p--) add_pkt(1, $urandom_range(40, 1));
      build_expected(MAXB_MAIN);
      run_traffic(0, 6000);
    end

    // Reset during beat 5 of a 10-beat s0 packet.
    do_reset();
    add_pkt(0, 10);
    build_expected(MAXB_MAIN);
    run_traffic(4, 100);
    check("mid_fires", s0_fires, 4);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check_reset();
    new_phase();
    drive_inputs();
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    add_pkt(1, 6);
    build_expected(MAXB_MAIN);
    drive_inputs();
    @(negedge clk);
    check("lat_idle_grant", grant, GNT_NONE);
    check("lat_idle_rdy", s1_if.tready, 0);
    @(posedge clk); #1;
    @(negedge clk);
    check("lat_grant", grant, GNT_S1);
    check("lat_rdy", s1_if.tready, 1);
    @(posedge clk); #1;
    i1 = 1; v1 = 1'b0;
    run_traffic(0, 100);
    check("post_rst_beats", nbeats, 6);

    // Watchdog: MAX_BEATS=16, s0 sends 20 beats with tlast on 20.
    do_reset();
    sent = 0; got = 0;
    for (int c = 0; c < 60; c++) begin
      w0_if.tvalid = (sent < 20);
      w0_if.tdata  = 64'(sent + 1) * 64'h0101_0101_0101_0101;
      w0_if.tkeep  = 8'hFF;
      w0_if.tlast  = (sent == 19);
      @(negedge clk);
      if (w0_if.tvalid && w0_if.tready) begin
        if (sent >= 16) check("wd_drain_grant", w_grant, GNT_S0);
        sent++;
      end
      if (wm_if.tvalid && wm_if.tready) begin
        got++;
        check("wd_beat", {wm_if.tdata, wm_if.tlast},
              {64'(got) * 64'h0101_0101_0101_0101, got == 16});
      end
      @(posedge clk); #1;
    end
    w0_if.tvalid = 1'b0;
    check("wd_sent", sent, 20);
    check("wd_got", got, 16);
    check("wd_trunc_set", w_trunc, 1);
    check("wd_grant_idle", w_grant, GNT_NONE);
    w_err_clr = 1'b1;
    @(posedge clk); #1;
    w_err_clr = 1'b0;
    check("wd_trunc_clr", w_trunc, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
